// File: rtl/fib_datapath_pkg.sv
// Shared definitions for the Fibonacci datapath slice.
//   - data width and register count
//   - ALU opcode set shared with the sequencer FSM
//   - buffCtrl bit indices and write-bus source encodings
//   - ALU flag word layout {C,L,F,Z,N}
package fib_datapath_pkg;

  localparam int WIDTH  = 16;
  localparam int NREGS  = 16;
  localparam int RSEL_W = $clog2(NREGS);

  typedef logic [7:0] alu_op_t;

  localparam alu_op_t OP_NOP = 8'h00;
  localparam alu_op_t OP_ADD = 8'h01;
  localparam alu_op_t OP_SUB = 8'h02;
  localparam alu_op_t OP_AND = 8'h03;
  localparam alu_op_t OP_OR  = 8'h04;
  localparam alu_op_t OP_XOR = 8'h05;
  localparam alu_op_t OP_MOV = 8'h06;

  // buffCtrl bit indices
  localparam int BC_IMM = 0;
  localparam int BC_ALU = 1;
  localparam int BC_RA  = 2;
  localparam int BC_RB  = 3;

  // write-bus source field {buffCtrl[BC_ALU], buffCtrl[BC_IMM]}
  localparam logic [1:0] SRC_IMM  = 2'b01;
  localparam logic [1:0] SRC_ALU  = 2'b10;
  localparam logic [1:0] SRC_BOTH = 2'b11;

  // flag word, MSB first: C(4) L(3) F(2) Z(1) N(0)
  typedef struct packed {
    logic c;
    logic l;
    logic f;
    logic z;
    logic n;
  } flags_t;

endpackage

// File: rtl/fib_datapath_if.sv
// Control-word / status bundle between the sequencer FSM and the datapath.
//   master : sequencer side, drives the control word, observes status
//   slave  : datapath side, consumes the control word, drives status
interface fib_datapath_if;
  import fib_datapath_pkg::*;

  logic [WIDTH-1:0]  initialR;
  logic [RSEL_W-1:0] regWrite;
  logic [RSEL_W-1:0] regRead1;
  logic [RSEL_W-1:0] regRead2;
  alu_op_t           ALUOp;
  logic [3:0]        buffCtrl;
  logic              regReset;
  logic              regWriteEn;

  logic [WIDTH-1:0]  result;
  flags_t            flags;
  logic              ovfSticky;
  logic              busErr;
  logic              wbValid;

  modport master (
    output initialR, regWrite, regRead1, regRead2, ALUOp, buffCtrl, regReset, regWriteEn,
    input  result, flags, ovfSticky, busErr, wbValid
  );

  modport slave (
    input  initialR, regWrite, regRead1, regRead2, ALUOp, buffCtrl, regReset, regWriteEn,
    output result, flags, ovfSticky, busErr, wbValid
  );

endinterface

// File: rtl/fib_datapath_regfile.sv
// 16x16 register file for the Fibonacci datapath.
//   clk, reset        : clock, async active-low reset
//   i_clr             : sync clear of every register, wins over write
//   i_we/i_waddr/i_wdata : single synchronous write port
//   i_raddr1/2 -> o_rdata1/2 : two combinational read ports (no bypass,
//                       a same-cycle write is not visible until next cycle)
module fib_datapath_regfile
  import fib_datapath_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [RSEL_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [RSEL_W-1:0] i_raddr1,
  input  logic [RSEL_W-1:0] i_raddr2,
  output logic [WIDTH-1:0]  o_rdata1,
  output logic [WIDTH-1:0]  o_rdata2
);

  logic [WIDTH-1:0] r_mem [NREGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/fib_datapath.sv
// Fibonacci datapath: register file, 16-bit ALU and registered write-back bus.
//   clk, reset : clock, async active-low reset clearing all state
//   bus        : slave side of fib_datapath_if
//                in : initialR, regWrite, regRead1/2, ALUOp, buffCtrl,
//                     regReset, regWriteEn
//                out: result, flags {C,L,F,Z,N}, ovfSticky, busErr, wbValid
module fib_datapath
  import fib_datapath_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  fib_datapath_if.slave bus
);

  logic [WIDTH-1:0] w_rd1, w_rd2;
  logic [WIDTH-1:0] w_op_a, w_op_b;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c, w_alu_f, w_alu_upd;
  flags_t           w_alu_flags;
  logic [1:0]       w_src;
  logic             w_src_ok, w_commit, w_alu_commit;
  logic [WIDTH-1:0] w_bus;

  logic [WIDTH-1:0] r_result;
  flags_t           r_flags;
  logic             r_ovf;
  logic             r_bus_err;
  logic             r_wb_valid;

  fib_datapath_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (bus.regReset),
    .i_we     (w_commit),
    .i_waddr  (bus.regWrite),
    .i_wdata  (w_bus),
    .i_raddr1 (bus.regRead1),
    .i_raddr2 (bus.regRead2),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2)
  );

  assign w_op_a = bus.buffCtrl[BC_RA] ? w_rd1 : '0;
  assign w_op_b = bus.buffCtrl[BC_RB] ? w_rd2 : '0;

  // bit WIDTH of the extended sum is the carry; of the difference, the borrow
  assign w_sum  = {1'b0, w_op_a} + {1'b0, w_op_b};
  assign w_diff = {1'b0, w_op_a} - {1'b0, w_op_b};

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_f   = 1'b0;
    w_alu_upd = 1'b1;
    case (bus.ALUOp)
      OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_f   = (w_op_a[WIDTH-1] == w_op_b[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != w_op_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = w_diff[WIDTH];
        w_alu_f   = (w_op_a[WIDTH-1] != w_op_b[WIDTH-1]) &&
                    (w_diff[WIDTH-1] != w_op_a[WIDTH-1]);
      end
      OP_AND:  w_alu_res = w_op_a & w_op_b;
      OP_OR:   w_alu_res = w_op_a | w_op_b;
      OP_XOR:  w_alu_res = w_op_a ^ w_op_b;
      OP_MOV:  w_alu_res = w_op_b;
      OP_NOP:  w_alu_upd = 1'b0;
      // unknown opcodes behave exactly like NOP
      default: w_alu_upd = 1'b0;
    endcase
  end

  always_comb begin
    w_alu_flags   = '0;
    w_alu_flags.c = w_alu_c;
    w_alu_flags.l = (w_op_a < w_op_b);
    w_alu_flags.f = w_alu_f;
    w_alu_flags.z = (w_alu_res == '0);
    w_alu_flags.n = w_alu_res[WIDTH-1];
  end

  assign w_src    = {bus.buffCtrl[BC_ALU], bus.buffCtrl[BC_IMM]};
  assign w_src_ok = (w_src == SRC_IMM) || (w_src == SRC_ALU);

  always_comb begin
    w_bus = '0;
    case (w_src)
      SRC_IMM: w_bus = bus.initialR;
      SRC_ALU: w_bus = w_alu_res;
      default: w_bus = '0;
    endcase
  end

  assign w_commit     = bus.regWriteEn && !bus.regReset && w_src_ok;
  assign w_alu_commit = w_commit && (w_src == SRC_ALU);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result   <= '0;
      r_flags    <= '0;
      r_ovf      <= 1'b0;
      r_bus_err  <= 1'b0;
      r_wb_valid <= 1'b0;
    end else begin
      r_bus_err  <= (w_src == SRC_BOTH);
      r_wb_valid <= w_commit;
      if (bus.regReset) begin
        r_flags <= '0;
        r_ovf   <= 1'b0;
      end else if (w_commit) begin
        r_result <= w_bus;
        if (w_alu_commit && w_alu_upd) r_flags <= w_alu_flags;
        if (w_alu_commit && (bus.ALUOp == OP_ADD) && w_alu_c) r_ovf <= 1'b1;
      end
    end
  end

  assign bus.result    = r_result;
  assign bus.flags     = r_flags;
  assign bus.ovfSticky = r_ovf;
  assign bus.busErr    = r_bus_err;
  assign bus.wbValid   = r_wb_valid;

endmodule

// File: tb/tb_fib_datapath.sv
module tb_fib_datapath;
  import fib_datapath_pkg::*;

  logic clk;
  logic reset;
  fib_datapath_if dp_if ();

  fib_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // reference state, kept as plain integers
  int m_reg [16];
  int m_result;
  int m_flags;
  int m_ovf;
  int m_bus_err;
  int m_wb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  task automatic model_clear_all();
    for (int i = 0; i < 16; i++) m_reg[i] = 0;
    m_result  = 0;
    m_flags   = 0;
    m_ovf     = 0;
    m_bus_err = 0;
    m_wb      = 0;
  endtask

  // Evaluate the control word currently on the interface as the next edge will.
  task automatic model_edge();
    int a, b, res, sres, c, f, sel, val;
    bit upd, commit;
    a = dp_if.buffCtrl[2] ? m_reg[dp_if.regRead1] : 0;
    b = dp_if.buffCtrl[3] ? m_reg[dp_if.regRead2] : 0;
    c = 0; f = 0; upd = 1; res = 0;
    case (int'(dp_if.ALUOp))
      1: begin
        res = (a + b) % 65536; c = (a + b > 65535);
        sres = sgn(a) + sgn(b); f = (sres > 32767 || sres < -32768);
      end
      2: begin
        res = (a - b + 65536) % 65536; c = (a < b);
        sres = sgn(a) - sgn(b); f = (sres > 32767 || sres < -32768);
      end
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: res = b;
      default: upd = 0;
    endcase
    sel = int'(dp_if.buffCtrl[1:0]);
    m_bus_err = (sel == 3);
    commit = dp_if.regWriteEn && !dp_if.regReset && (sel == 1 || sel == 2);
    if (dp_if.regReset) begin
      for (int i = 0; i < 16; i++) m_reg[i] = 0;
      m_ovf = 0; m_flags = 0; m_wb = 0;
    end else if (commit) begin
      val = (sel == 1) ? int'(dp_if.initialR) : res;
      m_reg[dp_if.regWrite] = val;
      m_result = val;
      m_wb = 1;
      if (sel == 2 && upd)
        m_flags = c * 16 + (a < b) * 8 + f * 4 + (res == 0) * 2 + (res >= 32768);
      if (sel == 2 && dp_if.ALUOp == 8'd1 && c == 1) m_ovf = 1;
    end else begin
      m_wb = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".result"},  32'(dp_if.result),    32'(m_result));
    chk({tag, ".flags"},   32'(dp_if.flags),     32'(m_flags));
    chk({tag, ".ovf"},     32'(dp_if.ovfSticky), 32'(m_ovf));
    chk({tag, ".busErr"},  32'(dp_if.busErr),    32'(m_bus_err));
    chk({tag, ".wbValid"}, 32'(dp_if.wbValid),   32'(m_wb));
  endtask

  task automatic drive(input logic [15:0] imm, input int rw, input int r1, input int r2,
                       input logic [7:0] op, input logic [3:0] bc, input logic rr,
                       input logic we);
    dp_if.initialR   = imm;
    dp_if.regWrite   = 4'(rw);
    dp_if.regRead1   = 4'(r1);
    dp_if.regRead2   = 4'(r2);
    dp_if.ALUOp      = op;
    dp_if.buffCtrl   = bc;
    dp_if.regReset   = rr;
    dp_if.regWriteEn = we;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // MOV R[i] <= R[i] exposes each register on result
  task automatic read_back_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      drive(16'h0, i, i, i, OP_MOV, 4'b1010, 1'b0, 1'b1);
      step(tag);
    end
  endtask

  initial begin
    bit seen_peak;
    n_vec = 0;
    n_err = 0;
    model_clear_all();
    reset = 1'b0;
    drive(16'h0, 0, 0, 0, OP_NOP, 4'b0000, 1'b0, 1'b0);
    #12;
    check_all("reset");
    reset = 1'b1;

    // immediate loads
    drive(16'd1, 0, 0, 0, OP_NOP, 4'b0001, 1'b0, 1'b1);
    step("imm_r0");
    chk("imm_r0.const", 32'(dp_if.result), 32'd1);
    drive(16'd1, 1, 0, 0, OP_NOP, 4'b0001, 1'b0, 1'b1);
    step("imm_r1");
    chk("imm_r1.flags0", 32'(dp_if.flags), 32'd0);

    // Fibonacci by alternating adds
    seen_peak = 0;
    for (int k = 0; k < 30; k++) begin
      if (k % 2 == 0) drive(16'h0, 1, 0, 1, OP_ADD, 4'b1110, 1'b0, 1'b1);
      else            drive(16'h0, 0, 1, 0, OP_ADD, 4'b1110, 1'b0, 1'b1);
      step("fib");
      if (seen_peak) begin
        chk("fib_wrap.result", 32'(dp_if.result), 32'd9489);
        chk("fib_wrap.C", 32'(dp_if.flags.c), 32'd1);
        chk("fib_wrap.ovf", 32'(dp_if.ovfSticky), 32'd1);
        seen_peak = 0;
      end
      if (m_result == 46368) begin
        chk("fib_peak.result", 32'(dp_if.result), 32'd46368);
        chk("fib_peak.ovf", 32'(dp_if.ovfSticky), 32'd0);
        seen_peak = 1;
      end
    end
    chk("fib_sticky_hold", 32'(dp_if.ovfSticky), 32'd1);

    // bus contention
    drive(16'hDEAD, 0, 0, 0, OP_MOV, 4'b0011, 1'b0, 1'b1);
    step("contend");
    chk("contend.busErr", 32'(dp_if.busErr), 32'd1);
    drive(16'h0, 0, 0, 0, OP_NOP, 4'b0000, 1'b0, 1'b0);
    step("contend_after");
    drive(16'h0, 0, 0, 0, OP_MOV, 4'b1010, 1'b0, 1'b1);
    step("contend_r0_kept");

    // SUB with borrow, then a read of the register being written
    drive(16'd3, 0, 0, 0, OP_NOP, 4'b0001, 1'b0, 1'b1);
    step("ld3");
    drive(16'd5, 1, 0, 0, OP_NOP, 4'b0001, 1'b0, 1'b1);
    step("ld5");
    drive(16'h0, 2, 0, 1, OP_SUB, 4'b1110, 1'b0, 1'b1);
    step("sub");
    chk("sub.const", 32'(dp_if.result), 32'hFFFE);
    chk("sub.flags", 32'(dp_if.flags), 32'b11001);
    drive(16'h0, 2, 2, 1, OP_SUB, 4'b1110, 1'b0, 1'b1);
    step("sub_old_read");
    chk("sub_old_read.const", 32'(dp_if.result), 32'hFFF9);

    // regReset beats a pending write
    drive(16'h1234, 3, 0, 0, OP_NOP, 4'b0001, 1'b1, 1'b1);
    step("regreset");
    chk("regreset.ovf", 32'(dp_if.ovfSticky), 32'd0);
    read_back_all("regreset_rd");

    // randomized control words
    for (int n = 0; n < 300; n++) begin
      logic [7:0] op;
      op = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      drive(16'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), op, 4'($urandom),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0));
      if (n == 150) begin
        #3;
        reset = 1'b0;
        model_clear_all();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #2;
        reset = 1'b1;
        read_back_all("async_rst_rd");
      end else begin
        step("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
